// File: rtl/card_shoe.sv
// ---------------------------------------------------------------------------
// card_shoe
//   52-card shoe feeding the blackjack game FSM. On a shuffle request the
//   deck is filled in rank/suit order, then permuted in place with a
//   Fisher-Yates pass driven by a 16-bit Fibonacci LFSR. When the pass is
//   done the shoe is ready, and it deals one card per pip pulse.
//
// Parameters
//   SEED_DEFAULT  LFSR seed used when the seed input is zero
//   SKIP_SHUFFLE  1 = leave the deck in fill order (test/demo mode)
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   synchronous, active-low reset
//   shuffle    in   1   pulse: refill and reshuffle (accepted in IDLE/READY)
//   seed       in   16  LFSR seed, sampled with an accepted shuffle
//   pip        in   1   pulse: deal the next card (accepted in READY)
//   number     out  4   rank of last dealt card, 1..13
//   suits      out  2   suit of last dealt card, 0..3
//   valid      out  1   pulse: number/suits were updated this cycle
//   empty      out  1   all 52 cards have been dealt
//   ready      out  1   deck shuffled, pips accepted
//   remaining  out  6   cards left to deal, 0..52
// ---------------------------------------------------------------------------
module card_shoe #(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
   parameter bit          SKIP_SHUFFLE = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        shuffle,
   input  logic [15:0] seed,
   input  logic        pip,
   output logic [3:0]  number,
   output logic [1:0]  suits,
   output logic        valid,
   output logic        empty,
   output logic        ready,
   output logic [5:0]  remaining
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_INIT,
      S_SHUFFLE,
      S_READY
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [5:0]  r_deck [0:51];
   logic [5:0]  r_k;
   logic [5:0]  r_i;
   logic [5:0]  r_dp;
   logic [15:0] r_lfsr;

   logic        w_fb;
   logic [5:0]  w_j;
   logic        w_swap;
   logic        w_start;
   logic        w_deal;
   logic        w_init_last;
   logic        w_shuf_last;
   logic        w_enter_ready;
   logic [5:0]  w_fill;
   logic [5:0]  w_card;

   // Taps 16,14,13,11 (1-based) of a maximal-length Fibonacci LFSR
   assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
   assign w_j    = r_lfsr[5:0];

   // A candidate j above i is rejected; only j in 0..i produces a swap
   assign w_swap        = (r_state == S_SHUFFLE) && (w_j <= r_i);
   assign w_start       = shuffle && ((r_state == S_IDLE) || (r_state == S_READY));
   // shuffle has priority over pip when both arrive in READY
   assign w_deal        = (r_state == S_READY) && pip && !shuffle && !empty;
   assign w_init_last   = (r_state == S_INIT) && (r_k == 6'd51);
   assign w_shuf_last   = w_swap && (r_i == 6'd1);
   assign w_enter_ready = (w_init_last && SKIP_SHUFFLE) || w_shuf_last;

   // Fill order: entry k holds rank k/4+1, suit k%4
   assign w_fill = {r_k[5:2] + 4'd1, r_k[1:0]};
   assign w_card = r_deck[r_dp];

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (shuffle) w_next = S_INIT;
         end
         S_INIT: begin
            if (r_k == 6'd51) w_next = SKIP_SHUFFLE ? S_READY : S_SHUFFLE;
         end
         S_SHUFFLE: begin
            if (w_shuf_last) w_next = S_READY;
         end
         S_READY: begin
            if (shuffle) w_next = S_INIT;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // ---- deck storage (contents meaningless until the next fill) ----
   always_ff @(posedge clk) begin
      if (r_state == S_INIT) begin
         r_deck[r_k] <= w_fill;
      end else if (w_swap) begin
         r_deck[r_i] <= r_deck[w_j];
         r_deck[w_j] <= r_deck[r_i];
      end
   end

   // ---- control, LFSR and deal outputs ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr    <= SEED_DEFAULT;
         r_k       <= 6'd0;
         r_i       <= 6'd0;
         r_dp      <= 6'd0;
         number    <= 4'd0;
         suits     <= 2'd0;
         valid     <= 1'b0;
         empty     <= 1'b0;
         ready     <= 1'b0;
         remaining <= 6'd0;
      end else begin
         valid <= 1'b0;

         if (r_state == S_SHUFFLE) begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
         end

         if (w_start) begin
            r_lfsr    <= (seed == 16'd0) ? SEED_DEFAULT : seed;
            r_k       <= 6'd0;
            ready     <= 1'b0;
            empty     <= 1'b0;
            remaining <= 6'd0;
         end

         if (r_state == S_INIT) begin
            r_k <= r_k + 6'd1;
            r_i <= 6'd51;
         end

         if (w_swap) begin
            r_i <= r_i - 6'd1;
         end

         if (w_enter_ready) begin
            r_dp      <= 6'd0;
            remaining <= 6'd52;
            ready     <= 1'b1;
            empty     <= 1'b0;
         end

         if (w_deal) begin
            number    <= w_card[5:2];
            suits     <= w_card[1:0];
            valid     <= 1'b1;
            r_dp      <= r_dp + 6'd1;
            remaining <= remaining - 6'd1;
            // empty rises together with the final card's valid pulse
            if (remaining == 6'd1) empty <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_card_shoe.sv
// ---------------------------------------------------------------------------
// tb_card_shoe
//   Directed bench for card_shoe. Two instances share all inputs:
//   u_ord uses SKIP_SHUFFLE=1 (deck stays in fill order, every card is
//   predictable), u_shf uses SKIP_SHUFFLE=0 (checked for permutation,
//   repeatability and seed handling).
// ---------------------------------------------------------------------------
module tb_card_shoe;

   logic        clk;
   logic        rst_n;
   logic        shuffle;
   logic [15:0] seed;
   logic        pip;

   logic [3:0]  a_number;
   logic [1:0]  a_suits;
   logic        a_valid, a_empty, a_ready;
   logic [5:0]  a_remaining;

   logic [3:0]  b_number;
   logic [1:0]  b_suits;
   logic        b_valid, b_empty, b_ready;
   logic [5:0]  b_remaining;

   int n_tests;
   int n_fail;

   logic [5:0] seqs [4][52];

   card_shoe #(.SEED_DEFAULT(16'hACE1), .SKIP_SHUFFLE(1'b1)) u_ord (
      .clk(clk), .rst_n(rst_n), .shuffle(shuffle), .seed(seed), .pip(pip),
      .number(a_number), .suits(a_suits), .valid(a_valid), .empty(a_empty),
      .ready(a_ready), .remaining(a_remaining)
   );

   card_shoe #(.SEED_DEFAULT(16'hACE1), .SKIP_SHUFFLE(1'b0)) u_shf (
      .clk(clk), .rst_n(rst_n), .shuffle(shuffle), .seed(seed), .pip(pip),
      .number(b_number), .suits(b_suits), .valid(b_valid), .empty(b_empty),
      .ready(b_ready), .remaining(b_remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; shuffle = 1'b0; pip = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic do_shuffle(input logic [15:0] s);
      seed = s; shuffle = 1'b1;
      tick();
      shuffle = 1'b0;
   endtask

   // Bounded wait for ready on one instance; a timeout is a failed check
   task automatic wait_ready(input bit use_b, input string name);
      int cyc;
      cyc = 0;
      while (((use_b ? b_ready : a_ready) !== 1'b1) && cyc < 20000) begin
         tick();
         cyc++;
      end
      n_tests++;
      if ((use_b ? b_ready : a_ready) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: ready=%b after %0d cycles, required 1", name,
                  use_b ? b_ready : a_ready, cyc);
      end
   endtask

   // Back-to-back deal of 52 cards from u_shf into seqs[idx]
   task automatic deal_b_all(input int idx);
      int nvalid;
      nvalid = 0;
      pip = 1'b1;
      for (int c = 0; c < 52; c++) begin
         tick();
         if (b_valid === 1'b1) nvalid++;
         seqs[idx][c] = {b_number, b_suits};
      end
      pip = 1'b0;
      n_tests++;
      if (nvalid !== 52) begin
         n_fail++;
         $display("FAIL deal_b_valid[%0d]: valid pulses=%0d, required 52", idx, nvalid);
      end
      n_tests++;
      if ({b_empty, b_remaining} !== {1'b1, 6'd0}) begin
         n_fail++;
         $display("FAIL deal_b_end[%0d]: empty=%b remaining=%0d, required 1/0",
                  idx, b_empty, b_remaining);
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if ({a_number, a_suits, a_valid, a_empty, a_ready, a_remaining} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_ord: n=%0d s=%0d v=%b e=%b r=%b rem=%0d, required all 0",
                  a_number, a_suits, a_valid, a_empty, a_ready, a_remaining);
      end
      n_tests++;
      if ({b_number, b_suits, b_valid, b_empty, b_ready, b_remaining} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_shf: n=%0d s=%0d v=%b e=%b r=%b rem=%0d, required all 0",
                  b_number, b_suits, b_valid, b_empty, b_ready, b_remaining);
      end
      // IDLE never starts on its own
      repeat (60) tick();
      n_tests++;
      if ({a_ready, b_ready} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_hold: ready a/b=%b%b, required 00", a_ready, b_ready);
      end
   endtask

   task automatic test_fill_order();
      do_reset();
      do_shuffle(16'h1234);
      // Fill takes 52 cycles after the accepting edge
      repeat (51) tick();
      n_tests++;
      if (a_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_latency_early: ready=%b, required 0", a_ready);
      end
      tick();
      n_tests++;
      if ({a_ready, a_empty, a_remaining} !== {1'b1, 1'b0, 6'd52}) begin
         n_fail++;
         $display("FAIL fill_ready: ready=%b empty=%b rem=%0d, required 1/0/52",
                  a_ready, a_empty, a_remaining);
      end
      for (int k = 0; k < 52; k++) begin
         pip = 1'b1;
         tick();
         pip = 1'b0;
         n_tests++;
         if ({a_valid, a_number, a_suits, a_remaining} !==
             {1'b1, 4'(k / 4 + 1), 2'(k % 4), 6'(51 - k)}) begin
            n_fail++;
            $display("FAIL fill_card[%0d]: v=%b n=%0d s=%0d rem=%0d, required 1/%0d/%0d/%0d",
                     k, a_valid, a_number, a_suits, a_remaining, k / 4 + 1, k % 4, 51 - k);
         end
         if (k == 51) begin
            n_tests++;
            if (a_empty !== 1'b1) begin
               n_fail++;
               $display("FAIL last_card_empty: empty=%b, required 1", a_empty);
            end
         end
         tick();
         n_tests++;
         if (a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_pulse[%0d]: valid=%b, required 0", k, a_valid);
         end
      end
   endtask

   task automatic test_exhausted();
      pip = 1'b1;
      tick();
      pip = 1'b0;
      n_tests++;
      if ({a_valid, a_number, a_suits, a_empty, a_remaining} !==
          {1'b0, 4'd13, 2'd3, 1'b1, 6'd0}) begin
         n_fail++;
         $display("FAIL pip_when_empty: v=%b n=%0d s=%0d e=%b rem=%0d, required 0/13/3/1/0",
                  a_valid, a_number, a_suits, a_empty, a_remaining);
      end
   endtask

   task automatic test_shuffle_perm();
      logic [63:0] seen;
      int dups;
      do_reset();
      do_shuffle(16'h1234);
      wait_ready(1'b1, "perm_ready1");
      deal_b_all(0);
      seen = 64'd0;
      dups = 0;
      for (int c = 0; c < 52; c++) begin
         if (seen[seqs[0][c]]) dups++;
         seen[seqs[0][c]] = 1'b1;
      end
      n_tests++;
      // codes {rank,suit} with rank 1..13 span 4..55
      if (seen !== 64'h00FF_FFFF_FFFF_FFF0 || dups !== 0) begin
         n_fail++;
         $display("FAIL perm_set: seen=%h dups=%0d, required 00fffffffffffff0/0", seen, dups);
      end
      do_shuffle(16'h1234);
      wait_ready(1'b1, "perm_ready2");
      deal_b_all(1);
      n_tests++;
      if (seqs[0] !== seqs[1]) begin
         n_fail++;
         $display("FAIL same_seed_repeat: first cards %h/%h, required identical order",
                  seqs[1][0], seqs[0][0]);
      end
      do_shuffle(16'h0000);
      wait_ready(1'b1, "perm_ready3");
      deal_b_all(2);
      do_shuffle(16'hACE1);
      wait_ready(1'b1, "perm_ready4");
      deal_b_all(3);
      n_tests++;
      if (seqs[2] !== seqs[3]) begin
         n_fail++;
         $display("FAIL zero_seed_default: first cards %h/%h, required identical order",
                  seqs[2][0], seqs[3][0]);
      end
   endtask

   task automatic test_pip_ignored();
      int vcount;
      int cyc;
      do_reset();
      do_shuffle(16'h5A5A);
      vcount = 0;
      cyc = 0;
      pip = 1'b1;
      while (b_ready !== 1'b1 && cyc < 20000) begin
         tick();
         cyc++;
         if (b_valid === 1'b1) vcount++;
      end
      pip = 1'b0;
      n_tests++;
      if (vcount !== 0 || b_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL pip_during_fill: valid pulses=%0d ready=%b, required 0/1", vcount, b_ready);
      end
      n_tests++;
      if (b_remaining !== 6'd52) begin
         n_fail++;
         $display("FAIL pip_no_queue: remaining=%0d, required 52", b_remaining);
      end
      shuffle = 1'b1; pip = 1'b1; seed = 16'h5A5A;
      tick();
      shuffle = 1'b0; pip = 1'b0;
      n_tests++;
      if ({b_valid, b_ready, b_remaining} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL shuffle_beats_pip: v=%b ready=%b rem=%0d, required 0/0/0",
                  b_valid, b_ready, b_remaining);
      end
   endtask

   task automatic test_reset_mid_shuffle();
      do_reset();
      do_shuffle(16'hBEEF);
      // 52 fill cycles, then a few cycles into the shuffle pass
      repeat (60) tick();
      n_tests++;
      if (b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_shuffle_busy: ready=%b, required 0", b_ready);
      end
      do_reset();
      n_tests++;
      if ({b_number, b_suits, b_valid, b_empty, b_ready, b_remaining} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_mid_shuffle: n=%0d s=%0d v=%b e=%b r=%b rem=%0d, required all 0",
                  b_number, b_suits, b_valid, b_empty, b_ready, b_remaining);
      end
      do_shuffle(16'hBEEF);
      wait_ready(1'b1, "after_reset_ready");
      n_tests++;
      if ({b_ready, b_empty, b_remaining} !== {1'b1, 1'b0, 6'd52}) begin
         n_fail++;
         $display("FAIL after_reset_deck: ready=%b empty=%b rem=%0d, required 1/0/52",
                  b_ready, b_empty, b_remaining);
      end
   endtask

   task automatic test_back_to_back();
      int nbad;
      do_reset();
      do_shuffle(16'h0001);
      wait_ready(1'b0, "b2b_ready1");
      for (int k = 0; k < 10; k++) begin
         pip = 1'b1;
         tick();
         pip = 1'b0;
         tick();
      end
      n_tests++;
      if ({a_number, a_suits, a_remaining} !== {4'd3, 2'd1, 6'd42}) begin
         n_fail++;
         $display("FAIL ten_deals: n=%0d s=%0d rem=%0d, required 3/1/42",
                  a_number, a_suits, a_remaining);
      end
      do_shuffle(16'h0001);
      n_tests++;
      if ({a_ready, a_empty, a_remaining} !== {1'b0, 1'b0, 6'd0}) begin
         n_fail++;
         $display("FAIL reshuffle_clear: ready=%b empty=%b rem=%0d, required 0/0/0",
                  a_ready, a_empty, a_remaining);
      end
      wait_ready(1'b0, "b2b_ready2");
      n_tests++;
      if ({a_empty, a_remaining} !== {1'b0, 6'd52}) begin
         n_fail++;
         $display("FAIL refill_count: empty=%b rem=%0d, required 0/52", a_empty, a_remaining);
      end
      nbad = 0;
      pip = 1'b1;
      for (int k = 0; k < 52; k++) begin
         tick();
         if ({a_valid, a_number, a_suits} !== {1'b1, 4'(k / 4 + 1), 2'(k % 4)}) nbad++;
      end
      pip = 1'b0;
      n_tests++;
      if (nbad !== 0) begin
         n_fail++;
         $display("FAIL b2b_deal: wrong cards=%0d, required 0", nbad);
      end
      n_tests++;
      if ({a_empty, a_remaining} !== {1'b1, 6'd0}) begin
         n_fail++;
         $display("FAIL b2b_end: empty=%b rem=%0d, required 1/0", a_empty, a_remaining);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      shuffle = 1'b0;
      pip     = 1'b0;
      seed    = 16'h0000;
      tick();
      test_reset();
      test_fill_order();
      test_exhausted();
      test_shuffle_perm();
      test_pip_ignored();
      test_reset_mid_shuffle();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
